// File: rtl/cmp_slice_sequencer.sv
// cmp_slice_sequencer: nibble-serial unsigned magnitude compare sequencer, MSB nibble first.
// Define CMP_EARLY_EXIT_EN to stop evaluating at the first differing nibble.
module cmp_slice_sequencer #(
  parameter int WIDTH = 16,
  localparam int NSLICE = WIDTH / 4,
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             slice_en,
  output logic [IW-1:0]    slice_idx
);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_q, b_q;
  logic sticky;
  logic [3:0] a_nib, b_nib;
  logic differ, last;
  // operands shift left each EVAL cycle so the active nibble is always on top
  always_comb begin
    a_nib = a_q[WIDTH-1 -: 4];
    b_nib = b_q[WIDTH-1 -: 4];
    differ = a_nib != b_nib;
`ifdef CMP_EARLY_EXIT_EN
    last = (slice_idx == '0) || differ;
`else
    last = slice_idx == '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sticky <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      gt <= 1'b0;
      eq <= 1'b0;
      lt <= 1'b0;
      slice_en <= 1'b0;
      slice_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q <= A;
          b_q <= B;
          slice_idx <= IW'(NSLICE - 1);
          sticky <= 1'b0;
          gt <= 1'b0;
          eq <= 1'b0;
          lt <= 1'b0;
          busy <= 1'b1;
          slice_en <= 1'b1;
          state <= EVAL;
        end
        EVAL: begin
          if (!sticky && differ) begin
            sticky <= 1'b1;
            gt <= a_nib > b_nib;
            lt <= a_nib < b_nib;
          end
          a_q <= a_q << 4;
          b_q <= b_q << 4;
          if (last) begin
            state <= DONE;
            slice_en <= 1'b0;
            done <= 1'b1;
            eq <= !(sticky || differ);
          end else
            slice_idx <= slice_idx - 1'b1;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_slice_sequencer.sv
// tb_cmp_slice_sequencer: directed checks of timing, results and reset behaviour for WIDTH=16.
module tb_cmp_slice_sequencer;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] A = '0, B = '0;
  logic busy, done, gt, eq, lt, slice_en;
  logic [1:0] slice_idx;
  int tests = 0, fails = 0;

  cmp_slice_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .busy(busy), .done(done),
    .gt(gt), .eq(eq), .lt(lt), .slice_en(slice_en), .slice_idx(slice_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int kfull, input int kearly);
`ifdef CMP_EARLY_EXIT_EN
    return kearly;
`else
    return kfull;
`endif
  endfunction

  // flags order: busy done gt eq lt slice_en
  task automatic compare(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int k, input logic [2:0] res);
    A = a; B = b; start = 1;
    step();
    start = 0; A = ~a; B = ~b;
    for (int c = 1; c <= k; c++) begin
      chk({tag, "_eval"}, {busy, done, slice_en}, 3'b101);
      chk({tag, "_idx"}, 16'(slice_idx), 16'(4 - c));
      step();
    end
    chk({tag, "_done"}, {busy, done, gt, eq, lt, slice_en}, {2'b11, res, 1'b0});
    step();
    chk({tag, "_hold"}, {busy, done, gt, eq, lt, slice_en}, {2'b00, res, 1'b0});
  endtask

  initial begin
    int k;
    start = 1; A = 16'h1234; B = 16'h1234;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("reset", {busy, done, gt, eq, lt, slice_en, slice_idx}, 8'h00);
    end
    rst = 0; start = 0;
    step();
    chk("idle", {busy, done, slice_en}, 3'b000);

    compare("equal", 16'h1234, 16'h1234, 4, 3'b010);
    compare("msb_diff", 16'h8000, 16'h7FFF, pick(4, 1), 3'b100);
    compare("lsb_diff", 16'h0001, 16'h0002, 4, 3'b001);
    compare("mid_gt", 16'h1235, 16'h1234, 4, 3'b100);
    compare("top_gt", 16'hFFFF, 16'h0FFF, pick(4, 1), 3'b100);
    compare("zero_eq", 16'h0000, 16'h0000, 4, 3'b010);

    k = pick(4, 2);
    A = 16'h00F0; B = 16'h0F00; start = 1;
    step();
    for (int c = 1; c <= k + 1; c++) begin
      start = (c == 2 || c == k + 1);
      A = 16'hFFFF; B = 16'h0000;
      chk("ign_done", {15'd0, done}, {15'd0, c == k + 1});
      chk("ign_busy", {15'd0, busy}, 16'd1);
      step();
    end
    start = 0;
    chk("ign_after", {busy, done, gt, eq, lt, slice_en}, 6'b000010);
    step();
    chk("ign_idle", {busy, done, lt}, 3'b001);
    compare("after_ign", 16'h4000, 16'h3000, pick(4, 1), 3'b100);

    A = 16'hFFFF; B = 16'hFFFE; start = 1;
    step();
    start = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst", {busy, done, gt, eq, lt, slice_en, slice_idx}, 8'h00);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_rst_quiet", {busy, done, slice_en}, 3'b000);
    end
    compare("post_rst", 16'hFFFF, 16'hFFFE, 4, 3'b100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cmp_slice_sequencer.md
# cmp_slice_sequencer

Sequencer for a low-power, nibble-serial magnitude comparator. It captures two WIDTH-bit operands and steps one shared 4-bit compare slice from the most-significant nibble to the least-significant. It reports greater-than, equal or less-than with a done pulse, and gates the slice off whenever no evaluation is in progress. It sits between the requesting control logic and the 4-bit gate-level comparator slice built from the team's NAND/NOR cells.

## Interface
Parameters:
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, number of nibble evaluations; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to compare A and B; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high in EVAL and DONE.
- done  output  1  one-cycle pulse; gt/eq/lt are valid in this cycle.
- gt  output  1  A > B (unsigned).
- eq  output  1  A == B.
- lt  output  1  A < B (unsigned).
- slice_en  output  1  power gate for the compare slice; high only in EVAL.
- slice_idx  output  clog2(NSLICE), minimum 1  nibble currently evaluated.

## Operation
- The FSM has three states: IDLE, EVAL and DONE.
- IDLE:
  - busy=0 and slice_en=0.
  - On start=1: A and B are registered, slice_idx=NSLICE-1, the sticky difference flag is cleared, and the FSM moves to EVAL.
- EVAL:
  - slice_en=1.
  - Each cycle compares nibble slice_idx of the captured A and B.
  - On the first differing nibble, gt or lt is set according to that nibble and the sticky flag is set. Later nibbles never override it.
  - If slice_idx==0, or the early-exit condition holds (see Configuration), the FSM moves to DONE. Otherwise slice_idx decrements.
- DONE:
  - done=1 and busy=1.
  - eq=1 only if the sticky flag never set.
  - The FSM returns to IDLE next cycle.
- Result hold: gt/eq/lt hold their value after DONE until the next accepted start clears them.
- Exclusivity: exactly one of gt/eq/lt is high from the DONE cycle until the next accepted start.
- Comparison is unsigned. There is no arithmetic and no carry chain; each nibble compare is purely combinational inside the slice.
- start while busy=1, including in the DONE cycle, is ignored and not queued.
- Changes on A/B after capture have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, gt=0, eq=0, lt=0, slice_en=0, slice_idx=0.
- rst has priority over start in the same cycle.
- rst asserted in EVAL or DONE:
  - IDLE is reached on that edge.
  - No done pulse is produced.
  - All outputs take their reset values.
- Cycle 0 is the edge where start is accepted. EVAL occupies cycles 1..k, and done is high in cycle k+1.
- The earliest next start is accepted in cycle k+2.
- Full-length run: k=NSLICE.
- Early exit: k = number of nibbles from the MSB nibble down to, and including, the first differing nibble.
- Equal operands always give k=NSLICE.

## Configuration
- Macro: CMP_EARLY_EXIT_EN.
- Defined:
  - EVAL moves to DONE in the cycle the first differing nibble is found.
  - slice_en drops immediately, saving switching energy.
  - Latency varies from 1 to NSLICE EVAL cycles.
- Undefined:
  - EVAL always runs all NSLICE cycles.
  - Latency is constant at NSLICE+1 cycles to done.
  - Results are identical to the defined case.

## Test plan
- Reset: hold rst for 2 cycles with start=1 -> all outputs 0, busy never rises.
- Equal operands: A=16'h1234, B=16'h1234, start in cycle 0 -> done in cycle 5 with eq=1, gt=0, lt=0, in both configurations.
- MSB difference: A=16'h8000, B=16'h7FFF:
  - gt=1 in both configurations.
  - CMP_EARLY_EXIT_EN: done in cycle 2, slice_en high for 1 cycle.
  - Without the macro: done in cycle 5.
- LSB difference: A=16'h0001, B=16'h0002 -> lt=1 with done in cycle 5 in both configurations; slice_idx sequence is 3, 2, 1, 0.
- Ignored start: A=16'h00F0, B=16'h0F00 accepted; pulse start with different operands in cycles 2 and 5 -> single done with lt=1; the next start is accepted only in cycle 6 or later.
- Reset mid-run: start with A=16'hFFFF, B=16'hFFFE; assert rst in cycle 2 -> cycle 3 in IDLE, no done pulse, all outputs 0.
